// File: rtl/uart_pkg.sv
// Shared types and constants for the extended UART receiver.
//   state_e      : receiver FSM states
//   PAR_*        : parity_mode encodings (2'b11 also means no parity)
//   MIN_CPB      : smallest bit period honoured, in clk cycles
//   clamp_cpb()  : applies the MIN_CPB floor to a requested bit period
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned MIN_CPB = 4;

  function automatic logic [31:0] clamp_cpb(input logic [31:0] cpb);
    return (cpb < MIN_CPB) ? 32'(MIN_CPB) : cpb;
  endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// Bundle of the receiver's line, configuration and held-word handshake signals.
//   master : drives the line and configuration, consumes the held word (bus side / bench)
//   slave  : the receiver itself
interface uart_rx_ext_if #(
  parameter int unsigned PAYLOAD_BITS = 8
) ();
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic [31:0]             cycles_per_bit;
  logic [1:0]              parity_mode;
  logic                    rx_ack;
  logic [PAYLOAD_BITS-1:0] rx_data;
  logic                    rx_valid;
  logic                    rx_parity_err;
  logic                    rx_frame_err;
  logic                    rx_break;
  logic                    rx_overrun;
  logic                    rx_busy;

  modport master (
    output uart_rxd, uart_rx_en, cycles_per_bit, parity_mode, rx_ack,
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy
  );

  modport slave (
    input  uart_rxd, uart_rx_en, cycles_per_bit, parity_mode, rx_ack,
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy
  );
endinterface

// File: rtl/uart_bit_sampler.sv
// Line synchroniser, bit-period counter and 3-sample majority voter.
//   i_rxd        : raw serial line
//   i_clear      : restart the counter at 0 on the next cycle (start-bit detect)
//   i_cpb        : latched bit period (already clamped to MIN_CPB)
//   o_rxs        : synchronised line
//   o_vote       : majority of samples at counter mid-1, mid, mid+1
//   o_vote_valid : high in the cycle the counter equals mid+1
//   o_bit_end    : high in the last cycle of the bit period
module uart_bit_sampler (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_rxd,
  input  logic        i_clear,
  input  logic [31:0] i_cpb,
  output logic        o_rxs,
  output logic        o_vote,
  output logic        o_vote_valid,
  output logic        o_bit_end
);
  logic        r_sync1, r_sync2;
  logic [31:0] r_cnt;
  logic        r_s0, r_s1;
  logic [31:0] w_mid;

  assign w_mid = i_cpb >> 1;
  assign o_rxs = r_sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign o_bit_end = (r_cnt == i_cpb - 32'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
    end else begin
      if (i_clear || o_bit_end) r_cnt <= '0;
      else                      r_cnt <= r_cnt + 32'd1;
      if (r_cnt == w_mid - 32'd1) r_s0 <= r_sync2;
      if (r_cnt == w_mid)         r_s1 <= r_sync2;
    end
  end

  // Third sample is the live synchronised line at mid+1.
  assign o_vote       = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
  assign o_vote_valid = (r_cnt == w_mid + 32'd1);

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with programmable bit period, parity, break/overrun detection and a
// valid/ack held-word interface.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : line, enable, configuration, held word, flags and busy (slave side)
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic          clk,
  input logic          resetn,
  uart_rx_ext_if.slave bus
);
  state_e                  r_state, w_state_d;
  logic [31:0]             r_cpb, w_cpb_d;
  logic [1:0]              r_mode, w_mode_d;
  logic [PAYLOAD_BITS-1:0] r_shift, w_shift_d;
  logic [3:0]              r_idx, w_idx_d;
  logic                    r_perr, w_perr_d, r_pbit, w_pbit_d, r_ferr, w_ferr_d;
  logic                    w_clear, w_complete, w_break, w_par_en;
  logic                    w_rxs, w_vote, w_vote_valid, w_bit_end;

  logic [PAYLOAD_BITS-1:0] r_data, w_data_d;
  logic                    r_valid, w_valid_d, r_ovr, w_ovr_d;
  logic                    r_perr_h, w_perr_h_d, r_ferr_h, w_ferr_h_d, r_brk_h, w_brk_h_d;

  uart_bit_sampler u_sampler (
    .clk          (clk),
    .resetn       (resetn),
    .i_rxd        (bus.uart_rxd),
    .i_clear      (w_clear),
    .i_cpb        (r_cpb),
    .o_rxs        (w_rxs),
    .o_vote       (w_vote),
    .o_vote_valid (w_vote_valid),
    .o_bit_end    (w_bit_end)
  );

  assign w_par_en = (r_mode == PAR_ODD) || (r_mode == PAR_EVEN);

  always_comb begin
    w_state_d  = r_state;
    w_cpb_d    = r_cpb;
    w_mode_d   = r_mode;
    w_shift_d  = r_shift;
    w_idx_d    = r_idx;
    w_perr_d   = r_perr;
    w_pbit_d   = r_pbit;
    w_ferr_d   = r_ferr;
    w_clear    = 1'b0;
    w_complete = 1'b0;
    w_break    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.uart_rx_en && !w_rxs) begin
          w_state_d = StStart;
          w_clear   = 1'b1;
          w_cpb_d   = clamp_cpb(bus.cycles_per_bit);
          w_mode_d  = bus.parity_mode;
          w_idx_d   = '0;
          w_perr_d  = 1'b0;
          w_pbit_d  = 1'b0;
          w_ferr_d  = 1'b0;
        end
      end
      StStart: begin
        if (w_vote_valid && w_vote) w_state_d = StIdle;
        else if (w_bit_end)         w_state_d = StData;
      end
      StData: begin
        if (w_vote_valid) w_shift_d = {w_vote, r_shift[PAYLOAD_BITS-1:1]};
        if (w_bit_end) begin
          if (r_idx == 4'(PAYLOAD_BITS - 1)) begin
            w_idx_d   = '0;
            w_state_d = w_par_en ? StParity : StStop;
          end else begin
            w_idx_d = r_idx + 4'd1;
          end
        end
      end
      StParity: begin
        if (w_vote_valid) begin
          w_perr_d = ((^r_shift) ^ w_vote) != (r_mode == PAR_ODD);
          w_pbit_d = w_vote;
        end
        if (w_bit_end) w_state_d = StStop;
      end
      StStop: begin
        if (w_vote_valid) begin
          if (!w_vote) w_ferr_d = 1'b1;
          // Last stop bit finishes at its mid-point so the next start edge is not missed.
          if (r_idx == 4'(STOP_BITS - 1)) begin
            w_complete = 1'b1;
            w_break    = (r_shift == '0) && !(w_par_en && r_pbit) && w_ferr_d;
            w_state_d  = w_break ? StBrkWait : StIdle;
          end
        end
        if (w_bit_end && (r_idx != 4'(STOP_BITS - 1))) w_idx_d = r_idx + 4'd1;
      end
      StBrkWait: begin
        if (w_rxs) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (!bus.uart_rx_en) begin
      w_state_d  = StIdle;
      w_complete = 1'b0;
    end
  end

  // Held word: ack releases it; a completing frame is only accepted if the slot is free
  // or being freed in the same cycle.
  always_comb begin
    w_data_d   = r_data;
    w_valid_d  = r_valid;
    w_perr_h_d = r_perr_h;
    w_ferr_h_d = r_ferr_h;
    w_brk_h_d  = r_brk_h;
    w_ovr_d    = r_ovr;
    if (r_valid && bus.rx_ack) begin
      w_valid_d = 1'b0;
      w_ovr_d   = 1'b0;
    end
    if (w_complete) begin
      if (!r_valid || bus.rx_ack) begin
        w_valid_d  = 1'b1;
        w_data_d   = r_shift;
        w_perr_h_d = w_perr_d;
        w_ferr_h_d = w_ferr_d;
        w_brk_h_d  = w_break;
      end else begin
        w_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= StIdle;
      r_cpb    <= 32'(MIN_CPB);
      r_mode   <= PAR_NONE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_perr   <= 1'b0;
      r_pbit   <= 1'b0;
      r_ferr   <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_h <= 1'b0;
      r_ferr_h <= 1'b0;
      r_brk_h  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cpb    <= w_cpb_d;
      r_mode   <= w_mode_d;
      r_shift  <= w_shift_d;
      r_idx    <= w_idx_d;
      r_perr   <= w_perr_d;
      r_pbit   <= w_pbit_d;
      r_ferr   <= w_ferr_d;
      r_data   <= w_data_d;
      r_valid  <= w_valid_d;
      r_perr_h <= w_perr_h_d;
      r_ferr_h <= w_ferr_h_d;
      r_brk_h  <= w_brk_h_d;
      r_ovr    <= w_ovr_d;
    end
  end

  assign bus.rx_data       = r_data;
  assign bus.rx_valid      = r_valid;
  assign bus.rx_parity_err = r_perr_h;
  assign bus.rx_frame_err  = r_ferr_h;
  assign bus.rx_break      = r_brk_h;
  assign bus.rx_overrun    = r_ovr;
  assign bus.rx_busy       = (r_state != StIdle);

endmodule
